debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  Multi-channel, symmetric push-button debouncer for the RGB mixer front panel.
//  - Each channel is synchronised, then filtered on both edges.
//  - Outputs a clean level plus one-clock rise/fall pulses per channel.
//  - Sample rate (PRESCALE) and required stability (STABLE_SAMPLES) are parameters.
//  - Sits between the raw pad inputs and the mixer's channel-select/step logic.
// PARAMETERS
//  CHANNELS        3   number of independent button inputs (>=1)
//  STABLE_SAMPLES  8   consecutive identical samples needed to change a level (>=1)
//  PRESCALE        1   clk cycles per sample tick (>=1; 1 = sample every clk)
//  RESET_LEVEL     0   level assumed for all channels during/after reset (0 or 1)
// PORTS
//  clk         in   1         system clock
//  reset       in   1         synchronous, active-high reset
//  button      in   CHANNELS  raw asynchronous button inputs
//  level       out  CHANNELS  debounced level per channel
//  rise        out  CHANNELS  1-clk pulse when level goes 0->1
//  fall        out  CHANNELS  1-clk pulse when level goes 1->0
//  sample_tick out  1         1-clk strobe marking each sample instant (debug/shared)
// BEHAVIOUR
//  Reset (reset=1 at a clk edge):
//   - Sync flops and level <= {CHANNELS{RESET_LEVEL}}; rise, fall, sample_tick <= 0.
//   - Prescaler count and all stability counters <= 0.
//   - Reset mid-count discards partial progress; no pulse is emitted by reset itself.
//  Synchroniser: 2-flop chain per channel, clocked every clk, independent of tick.
//  Prescaler: pcnt counts 0..PRESCALE-1 and wraps.
//   - sample_tick is registered; high the cycle after pcnt==PRESCALE-1.
//   - PRESCALE=1: sample_tick constantly 1 after the first post-reset edge.
//   - pcnt width is $clog2(PRESCALE), min 1 bit.
//  Per channel, evaluated only on clk edges where the tick is active (s = sync output):
//   - s == level: cnt <= 0.
//   - s != level and cnt == STABLE_SAMPLES-1: level <= s, cnt <= 0; rise<=s, fall<=~s.
//   - s != level otherwise: cnt <= cnt + 1.
//   - cnt width is $clog2(STABLE_SAMPLES), min 1 bit; it never exceeds STABLE_SAMPLES-1.
//   - Any sample equal to level restarts the count, so glitches shorter than
//     STABLE_SAMPLES samples never reach level.
//  rise/fall: registered, coincident with the level update, high exactly one clk;
//   forced 0 on every other cycle, including non-tick cycles.
//  Latency (PRESCALE=1): input stable from capturing edge E0 -> level/pulse update
//   at edge E0+STABLE_SAMPLES+1. PRESCALE>1 adds up to PRESCALE-1 extra cycles per
//   sample, depending on tick phase.
//  Channels are fully independent; simultaneous transitions on several channels
//   each produce their own pulse in the same cycle.
//  A held level, including RESET_LEVEL held from reset, never generates pulses.
// TESTING
//  1 CH=3,SS=4,PS=1,RL=0: button[0] 0->1 held -> level[0]=1 & rise[0]=1 for one clk
//    at 5th edge after capture; other channels stay 0.
//  2 Same cfg: button[1] 3-clk high glitch then low -> level[1] stays 0, no rise/fall.
//  3 Same cfg: release held button[2] -> fall[2] one clk, level[2]=0, latency 5 clks.
//  4 PS=4,SS=2: step button[0] high -> level changes 2-3 samples (8-12 clks) later;
//    sample_tick period is exactly 4 clks.
//  5 Mid-count reset: button[0] high 2 clks into count, assert reset 1 clk ->
//    all outputs 0, and the count restarts from 0 after reset.
//  6 RL=1, buttons held 1 through reset -> no pulses; all three pressed together
//    -> three simultaneous fall pulses in the same cycle.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel symmetric push-button debouncer.
// Every channel is synchronised, filtered on both edges, and pulsed on each level change.
//
// Parameters:
//   CHANNELS       number of independent button inputs (>=1)
//   STABLE_SAMPLES consecutive identical samples needed to change a level (>=1)
//   PRESCALE       clk cycles per sample tick (>=1, 1 = sample every clk)
//   RESET_LEVEL    level assumed for every channel during and after reset
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   button      raw asynchronous button inputs, one bit per channel
//   level       debounced level per channel
//   rise        one-clk pulse when a level goes 0->1
//   fall        one-clk pulse when a level goes 1->0
//   sample_tick one-clk strobe marking each sample instant
module debounce_multi #(
    parameter int CHANNELS       = 3,
    parameter int STABLE_SAMPLES = 8,
    parameter int PRESCALE       = 1,
    parameter bit RESET_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                sample_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;

    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CLAST = CW'(STABLE_SAMPLES - 1);

    // Two-flop synchroniser, clocked every cycle regardless of the tick.
    // Seeded with RESET_LEVEL so a button held at that level never looks
    // like a change once reset is released.
    logic [CHANNELS-1:0] sync_q1;
    logic [CHANNELS-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= {CHANNELS{RESET_LEVEL}};
            sync_q2 <= {CHANNELS{RESET_LEVEL}};
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
        end
    end

    // Prescaler. The tick is registered, so it is high on the cycle after
    // the count reaches its last value; with PRESCALE=1 the count is stuck
    // at 0 and the tick stays high from the first edge after reset.
    logic [PW-1:0] pcnt;
    logic          pwrap;

    assign pwrap = (pcnt == PLAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt        <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= pwrap;
            pcnt        <= pwrap ? '0 : pcnt + PW'(1);
        end
    end

    // Per-channel stability filter. The counter tracks how many consecutive
    // samples have disagreed with the current level; any agreeing sample
    // clears it, so only an unbroken run of STABLE_SAMPLES flips the level.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          lvl_q;
        logic          lvl_d;
        logic          rise_q;
        logic          rise_d;
        logic          fall_q;
        logic          fall_d;
        logic          smp;
        logic          differ;
        logic          expired;

        assign smp     = sync_q2[g];
        assign differ  = smp ^ lvl_q;
        assign expired = (cnt_q == CLAST);

        always_comb begin
            cnt_d  = cnt_q;
            lvl_d  = lvl_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (sample_tick) begin
                if (!differ) begin
                    cnt_d = '0;
                end else if (expired) begin
                    cnt_d  = '0;
                    lvl_d  = smp;
                    rise_d = smp;
                    fall_d = ~smp;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q  <= '0;
                lvl_q  <= RESET_LEVEL;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                lvl_q  <= lvl_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign level[g] = lvl_q;
        assign rise[g]  = rise_q;
        assign fall[g]  = fall_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: three instances with different configurations,
// a sample-window model checked every cycle, plus directed literal checks.
module tb_debounce_multi;

    logic       clk;
    logic       rst  [3];
    logic [2:0] btn  [3];
    logic [2:0] lvl  [3];
    logic [2:0] rise [3];
    logic [2:0] fall [3];
    logic       tick [3];

    int n_chk;
    int n_fail;
    bit chk_en;

    // a: SS=4 PS=1 RL=0   b: SS=2 PS=4 RL=0   c: SS=4 PS=1 RL=1
    int   ss_p [3] = '{4, 2, 4};
    int   ps_p [3] = '{1, 4, 1};
    logic rl_p [3] = '{1'b0, 1'b0, 1'b1};

    debounce_multi #(
        .CHANNELS(3), .STABLE_SAMPLES(4), .PRESCALE(1), .RESET_LEVEL(1'b0)
    ) u_a (
        .clk(clk), .reset(rst[0]), .button(btn[0]), .level(lvl[0]),
        .rise(rise[0]), .fall(fall[0]), .sample_tick(tick[0])
    );

    debounce_multi #(
        .CHANNELS(3), .STABLE_SAMPLES(2), .PRESCALE(4), .RESET_LEVEL(1'b0)
    ) u_b (
        .clk(clk), .reset(rst[1]), .button(btn[1]), .level(lvl[1]),
        .rise(rise[1]), .fall(fall[1]), .sample_tick(tick[1])
    );

    debounce_multi #(
        .CHANNELS(3), .STABLE_SAMPLES(4), .PRESCALE(1), .RESET_LEVEL(1'b1)
    ) u_c (
        .clk(clk), .reset(rst[2]), .button(btn[2]), .level(lvl[2]),
        .rise(rise[2]), .fall(fall[2]), .sample_tick(tick[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: inputs reach the filter two clocks late; sample instants fall
    // every PRESCALE edges after reset; a level flips when the newest
    // STABLE_SAMPLES samples all disagree with it.
    logic [2:0] m_d1   [3];
    logic [2:0] m_d2   [3];
    logic [2:0] m_lvl  [3];
    logic [2:0] m_rise [3];
    logic [2:0] m_fall [3];
    logic       m_tick [3];
    int         m_n    [3];
    logic       hist   [3][3][8];

    always @(posedge clk) begin : model
        bit all_diff;
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                m_d1[i]   = {3{rl_p[i]}};
                m_d2[i]   = {3{rl_p[i]}};
                m_lvl[i]  = {3{rl_p[i]}};
                m_rise[i] = 3'b000;
                m_fall[i] = 3'b000;
                m_tick[i] = 1'b0;
                m_n[i]    = 0;
                for (int c = 0; c < 3; c++)
                    for (int k = 0; k < 8; k++)
                        hist[i][c][k] = rl_p[i];
            end else begin
                m_rise[i] = 3'b000;
                m_fall[i] = 3'b000;
                if (m_tick[i]) begin
                    for (int c = 0; c < 3; c++) begin
                        for (int k = 7; k > 0; k--)
                            hist[i][c][k] = hist[i][c][k-1];
                        hist[i][c][0] = m_d2[i][c];
                        all_diff = 1'b1;
                        for (int k = 0; k < ss_p[i]; k++)
                            if (hist[i][c][k] == m_lvl[i][c])
                                all_diff = 1'b0;
                        if (all_diff) begin
                            m_lvl[i][c]  = m_d2[i][c];
                            m_rise[i][c] = m_d2[i][c];
                            m_fall[i][c] = ~m_d2[i][c];
                        end
                    end
                end
                m_d2[i]   = m_d1[i];
                m_d1[i]   = btn[i];
                m_n[i]    = m_n[i] + 1;
                m_tick[i] = ((m_n[i] % ps_p[i]) == 0);
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("inst%0d level", i), 32'(lvl[i]), 32'(m_lvl[i]));
                chk($sformatf("inst%0d rise", i), 32'(rise[i]), 32'(m_rise[i]));
                chk($sformatf("inst%0d fall", i), 32'(fall[i]), 32'(m_fall[i]));
                chk($sformatf("inst%0d tick", i), 32'(tick[i]), 32'(m_tick[i]));
            end
        end
    end

    int   bv [7] = '{1, 0, 1, 0, 1, 0, 1};
    int   bh [7] = '{3, 5, 2, 9, 12, 4, 6};
    logic [2:0] seen;
    bit   got_tick;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        btn[0] = 3'b000;
        btn[1] = 3'b000;
        btn[2] = 3'b111;
        step(2);
        chk("reset level a", 32'(lvl[0]), 32'h0);
        chk("reset level c", 32'(lvl[2]), 32'h7);
        chk("reset tick a", 32'(tick[0]), 32'h0);
        chk("reset rise a", 32'(rise[0]), 32'h0);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        step(10);

        // Press ch0: level and rise appear at the 5th edge after capture
        btn[0] = 3'b001;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t1 level before", 32'(lvl[0]), 32'h0);
        end
        step(1);
        chk("t1 level", 32'(lvl[0]), 32'h1);
        chk("t1 rise", 32'(rise[0]), 32'h1);
        step(1);
        chk("t1 rise width", 32'(rise[0]), 32'h0);
        chk("t1 level held", 32'(lvl[0]), 32'h1);

        // 3-clk glitch on ch1 never reaches the level
        btn[0] = 3'b011;
        step(3);
        btn[0] = 3'b001;
        seen = 3'b000;
        for (int k = 0; k < 12; k++) begin
            step(1);
            seen = seen | (lvl[0] & 3'b010) | (rise[0] & 3'b010)
                        | (fall[0] & 3'b010);
        end
        chk("t2 glitch", 32'(seen), 32'h0);

        // Hold ch2, then release: fall after 5 clks
        btn[0] = 3'b101;
        step(10);
        chk("t3 level pressed", 32'(lvl[0]), 32'h5);
        btn[0] = 3'b001;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t3 level before", 32'(lvl[0]), 32'h5);
        end
        step(1);
        chk("t3 fall", 32'(fall[0]), 32'h4);
        chk("t3 level", 32'(lvl[0]), 32'h1);
        step(1);
        chk("t3 fall width", 32'(fall[0]), 32'h0);

        // Mid-count reset with ch1 held high: no pulse from reset itself,
        // count restarts from zero afterwards
        btn[0] = 3'b010;
        step(10);
        chk("t5 level pre", 32'(lvl[0]), 32'h2);
        btn[0] = 3'b011;
        step(4);
        rst[0] = 1'b1;
        step(1);
        chk("t5 reset level", 32'(lvl[0]), 32'h0);
        chk("t5 reset fall", 32'(fall[0]), 32'h0);
        chk("t5 reset rise", 32'(rise[0]), 32'h0);
        chk("t5 reset tick", 32'(tick[0]), 32'h0);
        rst[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t5 level before", 32'(lvl[0]), 32'h0);
        end
        step(1);
        chk("t5 level", 32'(lvl[0]), 32'h3);
        chk("t5 rise both", 32'(rise[0]), 32'h3);

        // PRESCALE=4: tick period, then a press aligned to a tick
        got_tick = 1'b0;
        for (int k = 0; k < 8 && !got_tick; k++) begin
            step(1);
            got_tick = tick[1];
        end
        chk("t4 tick found", 32'(got_tick), 32'h1);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("t4 tick period", 32'(tick[1]), (k == 3) ? 32'h1 : 32'h0);
        end
        btn[1] = 3'b001;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("t4 level before", 32'(lvl[1]), 32'h0);
        end
        step(1);
        chk("t4 level", 32'(lvl[1]), 32'h1);
        chk("t4 rise", 32'(rise[1]), 32'h1);

        // Bounce pattern on instance b, checked by the model only
        for (int v = 0; v < 7; v++) begin
            btn[1] = (bv[v] != 0) ? 3'b110 : 3'b011;
            step(bh[v]);
        end
        btn[1] = 3'b000;
        step(20);
        chk("t4 final level", 32'(lvl[1]), 32'h0);

        // RESET_LEVEL=1 held through reset, then all released together
        chk("t6 held level", 32'(lvl[2]), 32'h7);
        btn[2] = 3'b000;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t6 level before", 32'(lvl[2]), 32'h7);
        end
        step(1);
        chk("t6 fall all", 32'(fall[2]), 32'h7);
        chk("t6 level", 32'(lvl[2]), 32'h0);
        chk("t6 no rise", 32'(rise[2]), 32'h0);
        step(5);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
